// File: rtl/conv_encode_punct.sv
// Rate-1/2 convolutional encoder with K-1 zero-bit tail termination and
// optional puncturing to rates 2/3 and 3/4, valid/ready on both sides.
module conv_encode_punct #(
  parameter int unsigned    K  = 9,
  parameter logic [K-1:0]   G0 = 9'o561,
  parameter logic [K-1:0]   G1 = 9'o753
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic [1:0] Mode,
  input  logic       InValid,
  output logic       InReady,
  input  logic       InBit,
  input  logic       InLast,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [1:0] Code,
  output logic [1:0] CodeMask,
  output logic       OutLast,
  output logic       Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  localparam logic [4:0] TAIL_LAST = 5'(K - 2);

  logic [1:0]   state;
  logic [K-2:0] s;
  logic [1:0]   p;
  logic [1:0]   mode_reg;
  logic [4:0]   tail_cnt;

  logic         out_free;
  logic         in_fire;
  logic         tail_fire;
  logic [1:0]   mode_eff;
  logic [1:0]   p_eff;
  logic [1:0]   p_next;
  logic [1:0]   punct_mask;
  logic [K-1:0] u;
  logic [1:0]   enc;

  always_comb begin
    out_free  = ~OutValid | OutReady;
    InReady   = Reset & (state != S_TAIL) & out_free;
    in_fire   = InValid & InReady;
    tail_fire = (state == S_TAIL) & out_free;

    // The first bit of a frame already uses the live Mode and phase 0.
    mode_eff  = (state == S_IDLE) ? Mode : mode_reg;
    p_eff     = (state == S_IDLE) ? 2'd0 : p;

    u   = {(state != S_TAIL) & InBit, s};
    enc = {^(u & G0), ^(u & G1)};

    punct_mask = 2'b11;
    p_next     = 2'd0;
    case (mode_eff)
      2'b01: begin
        punct_mask = (p_eff == 2'd0) ? 2'b11 : 2'b10;
        p_next     = (p_eff == 2'd0) ? 2'd1 : 2'd0;
      end
      2'b10: begin
        case (p_eff)
          2'd0:    begin punct_mask = 2'b11; p_next = 2'd1; end
          2'd1:    begin punct_mask = 2'b10; p_next = 2'd2; end
          default: begin punct_mask = 2'b01; p_next = 2'd0; end
        endcase
      end
      default: ;
    endcase

    // The FSM drops to IDLE as soon as the last tail symbol is loaded; the
    // pending OutLast symbol keeps Busy high until it is consumed.
    Busy = (state != S_IDLE) | (OutValid & OutLast);
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      s        <= '0;
      p        <= '0;
      mode_reg <= '0;
      tail_cnt <= '0;
      OutValid <= 1'b0;
      OutLast  <= 1'b0;
      Code     <= '0;
      CodeMask <= '0;
    end else begin
      if (in_fire) begin
        if (state == S_IDLE) mode_reg <= Mode;
        p        <= p_next;
        s        <= u[K-1:1];
        Code     <= enc & punct_mask;
        CodeMask <= punct_mask;
        OutLast  <= 1'b0;
        OutValid <= 1'b1;
        tail_cnt <= '0;
        state    <= InLast ? S_TAIL : S_DATA;
      end else if (tail_fire) begin
        s        <= u[K-1:1];
        Code     <= enc;
        CodeMask <= 2'b11;
        OutValid <= 1'b1;
        tail_cnt <= tail_cnt + 5'd1;
        if (tail_cnt == TAIL_LAST) begin
          OutLast <= 1'b1;
          state   <= S_IDLE;
        end else begin
          OutLast <= 1'b0;
        end
      end else if (OutReady) begin
        OutValid <= 1'b0;
        OutLast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encode_punct.sv
// Scoreboard bench: a K=3 (7,5) instance and a default K=9 instance, checked
// against a convolution-sum reference model under random backpressure.
module tb_conv_encode_punct;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] mode      [2];
  logic       in_valid  [2];
  logic       in_bit    [2];
  logic       in_last   [2];
  logic       out_ready [2];
  bit         bp_en     [2];

  logic       ir_a, ov_a, ol_a, bz_a, ir_b, ov_b, ol_b, bz_b;
  logic [1:0] cd_a, cm_a, cd_b, cm_b;

  logic       o_ready [2];
  logic       o_valid [2];
  logic       o_last  [2];
  logic       o_busy  [2];
  logic [1:0] o_code  [2];
  logic [1:0] o_mask  [2];

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];

  conv_encode_punct #(.K(3), .G0(3'o7), .G1(3'o5)) dut_a (
    .CLOCK(clk), .Reset(rst_n), .Mode(mode[0]), .InValid(in_valid[0]),
    .InReady(ir_a), .InBit(in_bit[0]), .InLast(in_last[0]), .OutValid(ov_a),
    .OutReady(out_ready[0]), .Code(cd_a), .CodeMask(cm_a), .OutLast(ol_a),
    .Busy(bz_a)
  );

  conv_encode_punct dut_b (
    .CLOCK(clk), .Reset(rst_n), .Mode(mode[1]), .InValid(in_valid[1]),
    .InReady(ir_b), .InBit(in_bit[1]), .InLast(in_last[1]), .OutValid(ov_b),
    .OutReady(out_ready[1]), .Code(cd_b), .CodeMask(cm_b), .OutLast(ol_b),
    .Busy(bz_b)
  );

  always_comb begin
    o_ready[0] = ir_a; o_valid[0] = ov_a; o_last[0] = ol_a; o_busy[0] = bz_a;
    o_code[0]  = cd_a; o_mask[0]  = cm_a;
    o_ready[1] = ir_b; o_valid[1] = ov_b; o_last[1] = ol_b; o_busy[1] = bz_b;
    o_code[1]  = cd_b; o_mask[1]  = cm_b;
  end

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (inst %0d): got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [4:0] q_pop(input int d);
    return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  function automatic void q_push(input int d, input logic [4:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  // Reference: each symbol is the XOR-sum of generator taps over the last K
  // input bits (zeros before the frame and for the tail), then masked.
  function automatic void push_frame(input int d, input bit bits[$], input logic [1:0] md);
    int          kk, n, total;
    logic [15:0] g0, g1;
    bit          c1, c0;
    logic [1:0]  m;
    kk = (d == 0) ? 3 : 9;
    g0 = (d == 0) ? 16'o7 : 16'o561;
    g1 = (d == 0) ? 16'o5 : 16'o753;
    n = bits.size();
    total = n + kk - 1;
    for (int t = 0; t < total; t++) begin
      c1 = 1'b0;
      c0 = 1'b0;
      for (int j = 0; j < kk; j++) begin
        if (t - j >= 0 && t - j < n && bits[t-j]) begin
          c1 ^= g0[kk-1-j];
          c0 ^= g1[kk-1-j];
        end
      end
      m = 2'b11;
      if (t < n) begin
        if (md == 2'b01) m = (t % 2 == 0) ? 2'b11 : 2'b10;
        else if (md == 2'b10) m = (t % 3 == 0) ? 2'b11 : ((t % 3 == 1) ? 2'b10 : 2'b01);
      end
      q_push(d, {(t == total - 1), m, {c1, c0} & m});
    end
  endfunction

  // Monitor: pops one expected symbol per transfer; stalled outputs must hold.
  logic [4:0] held   [2];
  bit         held_v [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        held_v[d] = 1'b0;
      end else if (o_valid[d]) begin
        if (held_v[d])
          check("stall_hold", d, {27'd0, o_last[d], o_mask[d], o_code[d]}, {27'd0, held[d]});
        if (out_ready[d]) begin
          if (q_size(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_symbol (inst %0d): got %0h expected none", d,
                     {o_last[d], o_mask[d], o_code[d]});
          end else begin
            check("symbol", d, {27'd0, o_last[d], o_mask[d], o_code[d]}, {27'd0, q_pop(d)});
          end
          held_v[d] = 1'b0;
        end else begin
          held_v[d] = 1'b1;
          held[d]   = {o_last[d], o_mask[d], o_code[d]};
        end
      end else begin
        held_v[d] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      out_ready[d] = bp_en[d] ? ($urandom_range(0, 99) < 60) : 1'b1;
  end

  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (o_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout (inst %0d): got no InReady expected InReady within 2000 cycles", d);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int d, input bit bits[$], input logic [1:0] md,
                            input bit change_mode);
    bit ok;
    push_frame(d, bits, md);
    mode[d] = md;
    for (int i = 0; i < bits.size(); i++) begin
      in_valid[d] = 1'b1;
      in_bit[d]   = bits[i];
      in_last[d]  = (i == bits.size() - 1);
      wait_ready(d, ok);
      if (!ok) begin
        in_valid[d] = 1'b0;
        return;
      end
      if (i == 0 && change_mode) mode[d] = md ^ 2'b11;
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (q_size(d) == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout (inst %0d): got %0d pending expected 0", d, q_size(d));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit f[$];
    bit g[$];
    bit imp[$];
    int cnt;
    logic [1:0] m1, m2;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 2'b00; in_valid[d] = 1'b0; in_bit[d] = 1'b0; in_last[d] = 1'b0;
      out_ready[d] = 1'b1; bp_en[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", d, {31'd0, o_valid[d]}, 0);
      check("rst_busy", d, {31'd0, o_busy[d]}, 0);
      check("rst_out_last", d, {31'd0, o_last[d]}, 0);
      check("rst_code_mask", d, {28'd0, o_code[d], o_mask[d]}, 0);
      check("rst_in_ready", d, {31'd0, o_ready[d]}, 0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // K=3 directed frame 1,0,1,1 in every mode (11 must behave as 00).
    f = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int md = 0; md < 4; md++) begin
      send_frame(0, f, 2'(md), 1'b0);
      wait_drain(0);
      check("idle_busy_k3", 0, {31'd0, o_busy[0]}, 0);
    end

    // K=9 impulse: tail holds InReady low for 8 cycles.
    imp = '{1'b1};
    send_frame(1, imp, 2'b00, 1'b0);
    check("busy_rise", 1, {31'd0, o_busy[1]}, 1);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!o_ready[1]) cnt++;
      else break;
    end
    check("tail_inready_low", 1, cnt, 8);
    wait_drain(1);
    check("busy_fall", 1, {31'd0, o_busy[1]}, 0);
    check("idle_out_valid", 1, {31'd0, o_valid[1]}, 0);

    // Back-to-back random frames under backpressure, mode flipped mid-frame.
    for (int d = 0; d < 2; d++) begin
      f.delete();
      g.delete();
      for (int i = 0; i < 20; i++) begin
        f.push_back(1'($urandom));
        g.push_back(1'($urandom));
      end
      m1 = 2'(1 + $urandom_range(0, 1));
      m2 = 2'(1 + $urandom_range(0, 1));
      bp_en[d] = 1'b1;
      send_frame(d, f, m1, 1'b1);
      send_frame(d, g, m2, 1'b0);
      bp_en[d] = 1'b0;
      wait_drain(d);
      check("b2b_busy_fall", d, {31'd0, o_busy[d]}, 0);
    end

    // Reset during the tail of a K=9 frame.
    send_frame(1, imp, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 1, {31'd0, o_valid[1]}, 0);
    check("midrst_busy", 1, {31'd0, o_busy[1]}, 0);
    check("midrst_out_last", 1, {31'd0, o_last[1]}, 0);
    check("midrst_in_ready", 1, {31'd0, o_ready[1]}, 0);
    exp_q1.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(1, imp, 2'b00, 1'b0);
    wait_drain(1);
    check("post_rst_busy", 1, {31'd0, o_busy[1]}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
